// File: rtl/reg_xfer_pkg.sv
// Shared constants, state encoding and opcode classes for the register-transfer sequencer.
package reg_xfer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_SWAP = 4'h3;
  localparam logic [3:0] OP_CLR  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;

  localparam logic [1:0] AL = 2'd0;
  localparam logic [1:0] BL = 2'd1;
  localparam logic [1:0] CL = 2'd2;
  localparam logic [1:0] DL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IMM  = 3'd1,
    ST_EXEC = 3'd2,
    ST_SWP1 = 3'd3,
    ST_SWP2 = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_MOV  = 3'd1,
    CLS_LDI  = 3'd2,
    CLS_SWAP = 3'd3,
    CLS_CLR  = 3'd4,
    CLS_INC  = 3'd5,
    CLS_ILL  = 3'd6
  } op_cls_t;

endpackage

// File: rtl/reg_xfer_decode.sv
// Combinational instruction decode: opcode class, operand indices and legality.
// SWAP is only legal when REG_XFER_SWAP_EN is defined.
module reg_xfer_decode
  import reg_xfer_pkg::*;
(
  input  logic [7:0] ir,
  output op_cls_t    op_cls,
  output logic [1:0] dst,
  output logic [1:0] src,
  output logic       legal
);

  // Opcode field to operation class.
  always_comb begin
    op_cls = CLS_ILL;
    legal  = 1'b1;
    dst    = ir[3:2];
    src    = ir[1:0];
    case (ir[7:4])
      OP_NOP:  op_cls = CLS_NOP;
      OP_MOV:  op_cls = CLS_MOV;
      OP_LDI:  op_cls = CLS_LDI;
`ifdef REG_XFER_SWAP_EN
      OP_SWAP: op_cls = CLS_SWAP;
`endif
      OP_CLR:  op_cls = CLS_CLR;
      OP_INC:  op_cls = CLS_INC;
      default: begin
        op_cls = CLS_ILL;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Multi-cycle register-file transfer sequencer (NOP/MOV/LDI/SWAP/CLR/INC).
// Define REG_XFER_SWAP_EN to build SWAP support (SWP1/SWP2 states and tmp register).
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  output logic       reg_r,
  output logic [7:0] reg_r_select,
  input  logic [7:0] reg_r_line,
  output logic       reg_w,
  output logic [7:0] reg_w_select,
  output logic [7:0] reg_w_line,
  output logic       busy,
  output logic       retire,
  output logic       err
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] ir_r;
  logic [7:0] imm_r;
  logic       err_r;
`ifdef REG_XFER_SWAP_EN
  logic [7:0] tmp_r;
`endif

  op_cls_t    cls_s;
  logic [1:0] dst_s;
  logic [1:0] src_s;
  logic       legal_s;
  logic       ready_s;
  logic       accept_s;
  logic       rd_en_s;
  logic       wr_en_s;
  logic [1:0] rd_sel_s;
  logic [1:0] wr_sel_s;
  logic [7:0] wr_line_s;
  logic       retire_s;

  reg_xfer_decode u_decode (
    .ir     (ir_r),
    .op_cls (cls_s),
    .dst    (dst_s),
    .src    (src_s),
    .legal  (legal_s)
  );

  assign ready_s  = !reset && ((state_r == ST_IDLE) || (state_r == ST_IMM));
  assign accept_s = instr_valid && ready_s;

  // State, instruction/immediate latches and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ir_r    <= 8'h00;
      imm_r   <= 8'h00;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s && (state_r == ST_IDLE)) ir_r <= instr_data;
      if (accept_s && (state_r == ST_IMM))  imm_r <= instr_data;
      if ((state_r == ST_EXEC) && !legal_s) err_r <= 1'b1;
    end
  end

`ifdef REG_XFER_SWAP_EN
  // Holds the source value read in SWP1 until the final dst write.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmp_r <= 8'h00;
    end else if (state_r == ST_SWP1) begin
      tmp_r <= reg_r_line;
    end
  end
`endif

  // Next-state and register-file port sequencing.
  always_comb begin
    state_nxt_s = state_r;
    rd_en_s     = 1'b0;
    wr_en_s     = 1'b0;
    rd_sel_s    = 2'd0;
    wr_sel_s    = 2'd0;
    wr_line_s   = 8'h00;
    retire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (instr_data[7:4] == OP_LDI) begin
          state_nxt_s = ST_IMM;
`ifdef REG_XFER_SWAP_EN
        end else if (instr_data[7:4] == OP_SWAP) begin
          state_nxt_s = ST_SWP1;
`endif
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_IMM: begin
        if (accept_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IMM;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_IDLE;
        retire_s    = 1'b1;
        case (cls_s)
          CLS_MOV: begin
            rd_en_s   = 1'b1;
            rd_sel_s  = src_s;
            wr_en_s   = 1'b1;
            wr_sel_s  = dst_s;
            wr_line_s = reg_r_line;
          end
          CLS_LDI: begin
            wr_en_s   = 1'b1;
            wr_sel_s  = dst_s;
            wr_line_s = imm_r;
          end
          CLS_CLR: begin
            wr_en_s   = 1'b1;
            wr_sel_s  = dst_s;
            wr_line_s = 8'h00;
          end
          CLS_INC: begin
            rd_en_s   = 1'b1;
            rd_sel_s  = dst_s;
            wr_en_s   = 1'b1;
            wr_sel_s  = dst_s;
            wr_line_s = reg_r_line + 8'd1;
          end
`ifdef REG_XFER_SWAP_EN
          CLS_SWAP: begin
            wr_en_s   = 1'b1;
            wr_sel_s  = dst_s;
            wr_line_s = tmp_r;
          end
`endif
          default: begin
            wr_en_s = 1'b0;
          end
        endcase
      end
`ifdef REG_XFER_SWAP_EN
      ST_SWP1: begin
        rd_en_s     = 1'b1;
        rd_sel_s    = src_s;
        state_nxt_s = ST_SWP2;
      end
      ST_SWP2: begin
        rd_en_s     = 1'b1;
        rd_sel_s    = dst_s;
        wr_en_s     = 1'b1;
        wr_sel_s    = src_s;
        wr_line_s   = reg_r_line;
        state_nxt_s = ST_EXEC;
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Reset forces every output low, so no write can commit on a reset edge.
  assign instr_ready  = ready_s;
  assign reg_r        = rd_en_s && !reset;
  assign reg_r_select = reset ? 8'h00 : {6'b000000, rd_sel_s};
  assign reg_w        = wr_en_s && !reset;
  assign reg_w_select = reset ? 8'h00 : {6'b000000, wr_sel_s};
  assign reg_w_line   = reset ? 8'h00 : wr_line_s;
  assign busy         = !reset && (state_r != ST_IDLE);
  assign retire       = retire_s && !reset;
  assign err          = err_r && !reset;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl with a behavioural 4x8 register file attached.
module tb_reg_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic       reg_r;
  logic [7:0] reg_r_select;
  logic [7:0] reg_r_line;
  logic       reg_w;
  logic [7:0] reg_w_select;
  logic [7:0] reg_w_line;
  logic       busy;
  logic       retire;
  logic       err;

  logic [7:0] regs [4] = '{default: 8'h00};
  int         w_cnt = 0;
  int         retire_cnt = 0;
  int         checks = 0;
  int         failures = 0;
  int         w0;
  int         r0;

  reg_xfer_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_ready  (instr_ready),
    .reg_r        (reg_r),
    .reg_r_select (reg_r_select),
    .reg_r_line   (reg_r_line),
    .reg_w        (reg_w),
    .reg_w_select (reg_w_select),
    .reg_w_line   (reg_w_line),
    .busy         (busy),
    .retire       (retire),
    .err          (err)
  );

  always #5 clk = ~clk;

  assign reg_r_line = regs[reg_r_select[1:0]];

  always @(posedge clk) begin
    if (reg_w) begin
      regs[reg_w_select[1:0]] <= reg_w_line;
      w_cnt <= w_cnt + 1;
    end
    if (retire) retire_cnt <= retire_cnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr_data  = b;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {7'd0, instr_ready}, 8'h01);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", {7'd0, busy}, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_ready", {7'd0, instr_ready}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_regw", {7'd0, reg_w}, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_ready", {7'd0, instr_ready}, 8'h01);
    check("post_rst_err", {7'd0, err}, 8'h00);
    @(posedge clk); #1;
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {7'd0, instr_ready}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_err", {7'd0, err}, 8'h00);
    check("reset_wline", reg_w_line, 8'h00);
    reset = 1'b0;
    #1;
    check("idle_ready", {7'd0, instr_ready}, 8'h01);
    @(posedge clk); #1;

    // LDI AL,0x5A
    r0 = retire_cnt;
    send(8'h20);
    send(8'h5A);
    wait_idle();
    check("ldi_al", regs[0], 8'h5A);
    check("ldi_retire", 8'(retire_cnt - r0), 8'h01);
    check("ldi_err", {7'd0, err}, 8'h00);

    // MOV CL,AL: port activity in EXEC, commit one edge after accept
    send(8'h18);
    check("mov_cl_pre", regs[2], 8'h00);
    check("mov_regw", {7'd0, reg_w}, 8'h01);
    check("mov_regr", {7'd0, reg_r}, 8'h01);
    check("mov_wsel", reg_w_select, 8'h02);
    check("mov_rsel", reg_r_select, 8'h00);
    check("mov_wline", reg_w_line, 8'h5A);
    @(posedge clk); #1;
    check("mov_cl", regs[2], 8'h5A);
    check("mov_al", regs[0], 8'h5A);
    wait_idle();

    // INC DL wraps 0xFF to 0x00
    send(8'h2C);
    send(8'hFF);
    wait_idle();
    check("ldi_dl", regs[3], 8'hFF);
    send(8'h5C);
    wait_idle();
    check("inc_dl_wrap", regs[3], 8'h00);

    // SWAP AL,BL
    send(8'h20);
    send(8'h11);
    wait_idle();
    send(8'h24);
    send(8'h22);
    wait_idle();
    w0 = w_cnt;
    send(8'h31);
`ifdef REG_XFER_SWAP_EN
    @(posedge clk); #1;
    check("swap_bl_t1", regs[1], 8'h22);
    @(posedge clk); #1;
    check("swap_bl_t2", regs[1], 8'h11);
    check("swap_al_t2", regs[0], 8'h11);
    @(posedge clk); #1;
    check("swap_al_t3", regs[0], 8'h22);
    wait_idle();
    check("swap_err", {7'd0, err}, 8'h00);
`else
    wait_idle();
    check("swap_al", regs[0], 8'h11);
    check("swap_bl", regs[1], 8'h22);
    check("swap_nowrite", 8'(w_cnt - w0), 8'h00);
    check("swap_err", {7'd0, err}, 8'h01);
`endif
    do_reset();

    // Illegal opcode: no write, sticky err through a NOP, cleared by reset
    w0 = w_cnt;
    send(8'hA7);
    wait_idle();
    check("ill_nowrite", 8'(w_cnt - w0), 8'h00);
    check("ill_err", {7'd0, err}, 8'h01);
    send(8'h00);
    wait_idle();
    check("nop_err_sticky", {7'd0, err}, 8'h01);
    check("nop_nowrite", 8'(w_cnt - w0), 8'h00);
    do_reset();
    check("ill_err_cleared", {7'd0, err}, 8'h00);

    // Reset while waiting for an immediate
    send(8'h2C);
    send(8'h77);
    wait_idle();
    check("ldi_dl77", regs[3], 8'h77);
    send(8'h28);
    check("imm_busy", {7'd0, busy}, 8'h01);
    w0 = w_cnt;
    do_reset();
    check("abort_nowrite", 8'(w_cnt - w0), 8'h00);
    check("abort_cl", regs[2], 8'h5A);
    check("abort_dl", regs[3], 8'h77);
    send(8'h4C);
    wait_idle();
    check("after_abort_clr_dl", regs[3], 8'h00);
    check("after_abort_cl", regs[2], 8'h5A);
    check("after_abort_err", {7'd0, err}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
